// File: rtl/revaluate_pkg.sv
// rtl/revaluate_pkg.sv - shared slice geometry and FSM state type for the slice streamer
package revaluate_pkg;

  localparam int SLICE_W    = 25;
  localparam int NUM_SLICES = 64;
  localparam int STATE_W    = SLICE_W * NUM_SLICES;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } stream_state_e;

  // Index width that stays legal for a degenerate single-slice state.
  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/revaluate_slice_mux.sv
// rtl/revaluate_slice_mux.sv - combinational pick of one slice out of the shadowed state
module revaluate_slice_mux #(
  parameter int SLICE_W    = revaluate_pkg::SLICE_W,
  parameter int NUM_SLICES = revaluate_pkg::NUM_SLICES,
  parameter int IDX_W      = revaluate_pkg::index_width(revaluate_pkg::NUM_SLICES)
) (
  input  logic [SLICE_W*NUM_SLICES-1:0] shadow,
  input  logic [IDX_W-1:0]              index,
  output logic [SLICE_W-1:0]            data
);

  always_comb begin
    data = '0;
    for (int k = 0; k < NUM_SLICES; k++) begin
      if (index == IDX_W'(k)) begin
        data = shadow[k*SLICE_W +: SLICE_W];
      end
    end
  end

endmodule

// File: rtl/revaluate_slice_streamer.sv
// rtl/revaluate_slice_streamer.sv - streams a captured state out one slice per handshake
// Optional slice_parity output when REVALUATE_SLICE_PARITY_EN is defined.
module revaluate_slice_streamer #(
  parameter int SLICE_W    = revaluate_pkg::SLICE_W,
  parameter int NUM_SLICES = revaluate_pkg::NUM_SLICES,
  localparam int IDX_W     = revaluate_pkg::index_width(NUM_SLICES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [SLICE_W*NUM_SLICES-1:0] state_in,
  output logic                          slice_valid,
  input  logic                          slice_ready,
  output logic [SLICE_W-1:0]            slice_data,
  output logic [IDX_W-1:0]              slice_index,
  output logic                          slice_last,
  output logic                          busy,
  output logic                          done,
`ifdef REVALUATE_SLICE_PARITY_EN
  output logic                          slice_parity,
`endif
  output logic                          load_err
);

  import revaluate_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);
  localparam logic [IDX_W-1:0] PREV_IDX = IDX_W'(NUM_SLICES - 2);

  stream_state_e                 state;
  logic [SLICE_W*NUM_SLICES-1:0] shadow;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      shadow      <= '0;
      slice_index <= '0;
      slice_valid <= 1'b0;
      slice_last  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            shadow      <= state_in;
            slice_index <= '0;
            slice_valid <= 1'b1;
            slice_last  <= (NUM_SLICES == 1);
            busy        <= 1'b1;
            state       <= STREAM;
          end
        end
        STREAM: begin
          if (load) begin
            load_err <= 1'b1;
          end
          if (slice_ready) begin
            // The final slice leaves STREAM instead of wrapping the index.
            if (slice_index == LAST_IDX) begin
              slice_valid <= 1'b0;
              slice_last  <= 1'b0;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              slice_index <= slice_index + 1'b1;
              slice_last  <= (slice_index == PREV_IDX);
            end
          end
        end
        DONE: begin
          if (load) begin
            load_err <= 1'b1;
          end
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          slice_valid <= 1'b0;
          slice_last  <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  revaluate_slice_mux #(
    .SLICE_W    (SLICE_W),
    .NUM_SLICES (NUM_SLICES),
    .IDX_W      (IDX_W)
  ) u_slice_mux (
    .shadow (shadow),
    .index  (slice_index),
    .data   (slice_data)
  );

`ifdef REVALUATE_SLICE_PARITY_EN
  assign slice_parity = slice_valid & (^slice_data);
`endif

endmodule
